// File: rtl/axis_fifo_rd_adapter.sv
// axis_fifo_rd_adapter: drains a first-word-fall-through FIFO of packed
// {last, keep, data} words into an AXI4-Stream master through a single output
// register. In packet mode a frame is only started once the writer has
// committed its last word, so the MAC never sees a mid-frame bubble.
module axis_fifo_rd_adapter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned KEEP_W      = DATA_W / 8,
  parameter bit          PACKET_MODE = 1'b1,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W+KEEP_W:0] fifo_rdata,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic                   frame_commit,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic [KEEP_W-1:0]      m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [FRAME_CNT_W-1:0] frames_pending,
  output logic                   in_frame,
  output logic                   starve_err,
  output logic                   cnt_ovf_err,
  output logic [15:0]            starve_cycles
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      tdata_q, tdata_d;
  logic [KEEP_W-1:0]      tkeep_q, tkeep_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;
  logic [FRAME_CNT_W-1:0] frames_pending_q, frames_pending_d;
  logic                   starve_err_q, starve_err_d;
  logic                   cnt_ovf_err_q, cnt_ovf_err_d;
  logic [15:0]            starve_cycles_q, starve_cycles_d;

  logic can_load;
  logic start_ok;
  logic pop;
  logic pop_last;
  logic head_last;
  logic starving;

  assign head_last = fifo_rdata[DATA_W+KEEP_W];

  // Pop decision: the output register must be free (or draining this cycle)
  // and the FSM must either be mid-frame or allowed to open a new frame.
  always_comb begin
    can_load = !tvalid_q || m_axis_tready;
    start_ok = PACKET_MODE ? (frames_pending_q != '0) : !fifo_empty;
    pop      = !fifo_empty && can_load &&
               ((state_q == STREAM) || ((state_q == IDLE) && start_ok));
    pop_last = pop && head_last;
    starving = (state_q == STREAM) && fifo_empty;
  end

  // Next-state for the output register, frame FSM, frame counter and
  // starvation bookkeeping.
  always_comb begin
    state_d          = state_q;
    tdata_d          = tdata_q;
    tkeep_d          = tkeep_q;
    tlast_d          = tlast_q;
    tvalid_d         = tvalid_q;
    frames_pending_d = frames_pending_q;
    starve_err_d     = starve_err_q;
    cnt_ovf_err_d    = cnt_ovf_err_q;
    starve_cycles_d  = starve_cycles_q;

    if (pop) begin
      tdata_d  = fifo_rdata[DATA_W-1:0];
      tkeep_d  = fifo_rdata[DATA_W +: KEEP_W];
      tlast_d  = head_last;
      tvalid_d = 1'b1;
      // A pop of a last word always ends (or never opens) a frame.
      state_d  = head_last ? IDLE : STREAM;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    // Commit and last-pop in the same cycle cancel out, including at the
    // ceiling, so that case is not an overflow.
    if (frame_commit && !pop_last) begin
      if (&frames_pending_q) begin
        cnt_ovf_err_d = 1'b1;
      end else begin
        frames_pending_d = frames_pending_q + FRAME_CNT_W'(1);
      end
    end else if (pop_last && !frame_commit && (frames_pending_q != '0)) begin
      frames_pending_d = frames_pending_q - FRAME_CNT_W'(1);
    end

    if (starving) begin
      if (starve_cycles_q != 16'hFFFF) begin
        starve_cycles_d = starve_cycles_q + 16'd1;
      end
      if (PACKET_MODE) begin
        starve_err_d = 1'b1;
      end
    end
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      tdata_q          <= '0;
      tkeep_q          <= '0;
      tlast_q          <= 1'b0;
      tvalid_q         <= 1'b0;
      frames_pending_q <= '0;
      starve_err_q     <= 1'b0;
      cnt_ovf_err_q    <= 1'b0;
      starve_cycles_q  <= '0;
    end else begin
      state_q          <= state_d;
      tdata_q          <= tdata_d;
      tkeep_q          <= tkeep_d;
      tlast_q          <= tlast_d;
      tvalid_q         <= tvalid_d;
      frames_pending_q <= frames_pending_d;
      starve_err_q     <= starve_err_d;
      cnt_ovf_err_q    <= cnt_ovf_err_d;
      starve_cycles_q  <= starve_cycles_d;
    end
  end

  assign fifo_rd_en     = pop;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tkeep   = tkeep_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tvalid  = tvalid_q;
  assign frames_pending = frames_pending_q;
  assign in_frame       = (state_q == STREAM);
  assign starve_err     = starve_err_q;
  assign cnt_ovf_err    = cnt_ovf_err_q;
  assign starve_cycles  = starve_cycles_q;

endmodule
